hilo_mult_unit: RTL and testbench
=================================

Name: hilo_mult_unit

Overview:
- Execute-stage HI/LO register unit; consumes the decoder's 4-bit HiLoEnable command plus rs/rt operands.
- Performs MTLO/MTHI writes in a single cycle.
- Performs MULT/MULTU/MADD/MSUB on an iterative multi-cycle datapath and asserts Busy so the hazard logic stalls the pipeline.
- Hi/Lo outputs feed the MFHI/MFLO writeback path.

Parameters:
- BITS_PER_CYCLE, 1, multiplier bits retired per iteration; legal values 1, 2, 4. ITER = 32/BITS_PER_CYCLE.

Ports:
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous active-low reset
- Valid  in  1  command qualifier; HiLoEnable is considered only when Valid=1
- HiLoEnable  in  4  0 none, 1 MTLO, 2 MTHI, 3 MULT, 4 MADD, 5 MSUB, 6-15 none
- Signed  in  1  1 signed operands, 0 unsigned (MULTU)
- A  in  32  rs operand
- B  in  32  rt operand
- Hi  out  32  HI register
- Lo  out  32  LO register
- Busy  out  1  multi-cycle operation in progress
- Done  out  1  one-cycle pulse, high the cycle after the HI/LO result write

Behaviour:
- Reset (async, Rst_n=0): Hi=0, Lo=0, Busy=0, Done=0; state IDLE; internal accumulator and counter cleared.
- FSM states:
  - IDLE: accepts commands.
  - MUL: ITER cycles of shift-add on operand magnitudes.
  - FIN: one cycle; apply sign correction, accumulate or subtract, write Hi/Lo.
- IDLE + Valid + code 1: Lo<=A at the next edge.
- IDLE + Valid + code 2: Hi<=A at the next edge.
- IDLE + Valid + code 3/4/5:
  - At the accept edge, capture |A| and |B|. The magnitude is taken only when Signed=1 and the operand is negative.
  - At the same edge, capture result sign = Signed & (A[31]^B[31]), capture the op code, go to MUL, set Busy=1.
- MUL: each cycle adds partial products for BITS_PER_CYCLE multiplier bits into a 64-bit product register; the counter decrements; the last iteration goes to FIN.
- FIN (registered result write; Busy<=0, state<=IDLE at the same edge):
  - P = sign ? -prod : prod (64-bit two's complement).
  - MULT: {Hi,Lo}<=P.
  - MADD: {Hi,Lo}<={Hi,Lo}+P, mod 2^64.
  - MSUB: {Hi,Lo}<={Hi,Lo}-P, mod 2^64.
  - MADD/MSUB use the Signed input exactly as MULT does.
- Timing: Busy stays high for exactly ITER+1 cycles (33 at default). Done=1 in the first cycle after Busy falls, then 0.
- Commands with Valid=1 while Busy=1 are ignored, including MTHI/MTLO. Hi/Lo are unchanged until FIN.
- Hi/Lo hold their values during MUL; MFHI reads during Busy return the pre-operation values.
- A new command may be accepted in the cycle Done=1; there is no idle bubble requirement.
- Codes 0 and 6-15: no state change.
- Reset asserted mid-operation: immediate return to reset values; no partial write.
- Operand 0x80000000 with Signed=1: magnitude is 2^31 and is held in a 33-bit magnitude register; no overflow.

Optional Feature:
- Macro HILO_ABORT_EN.
- Defined:
  - Adds input Abort (1 bit).
  - Abort=1 in MUL or FIN returns the FSM to IDLE at the next edge, with Busy<=0, no Hi/Lo write, and no Done pulse.
  - Abort in IDLE has no effect.
  - Abort has priority over a same-cycle FIN write.
  - Abort does not block a same-cycle IDLE accept.
- Undefined: no Abort port; operations always run to completion.

Test Plan:
- Reset then MTLO A=0x12345678, then MTHI A=0xCAFEF00D -> Lo=0x12345678 one cycle after the first; Hi=0xCAFEF00D one cycle after the second; Busy stays 0.
- MULT Signed=1, A=0xFFFFFFFD, B=7 -> Busy high exactly 33 cycles; then Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; Done pulses once.
- MULT Signed=0, same operands -> Hi=0x00000006, Lo=0xFFFFFFEB.
- Preload Hi=0, Lo=10, then MADD Signed=1, A=2, B=3 -> Lo=16, Hi=0. Preload Lo=5, then MSUB A=2, B=3 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFF.
- MULT Signed=1, A=B=0x80000000; during Busy issue MTLO A=0x1 -> MTLO ignored; result Hi=0x40000000, Lo=0x00000000.
- Start MULT, drive Rst_n low at cycle 10 -> Hi=Lo=0 and Busy=0 immediately; no Done. With HILO_ABORT_EN, Abort at cycle 10 leaves Hi/Lo at their prior values and Busy=0 next cycle.

Source files
------------

// File: rtl/hilo_mult_unit.sv
// HI/LO register unit: single-cycle MTHI/MTLO, iterative MULT/MULTU/MADD/MSUB.
// Optional HILO_ABORT_EN macro adds an Abort input that cancels an in-flight multiply.
module hilo_mult_unit #(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Valid,
    input  logic [3:0]  HiLoEnable,
    input  logic        Signed,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        Busy,
    output logic        Done
`ifdef HILO_ABORT_EN
    ,
    input  logic        Abort
`endif
);

    localparam int unsigned ITER  = 32 / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = $clog2(ITER + 1);

    localparam logic [3:0] OpMtlo = 4'd1;
    localparam logic [3:0] OpMthi = 4'd2;
    localparam logic [3:0] OpMult = 4'd3;
    localparam logic [3:0] OpMadd = 4'd4;
    localparam logic [3:0] OpMsub = 4'd5;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StFin
    } state_t;

    state_t                    r_state, w_state_nxt;
    logic [31:0]               r_hi, w_hi_nxt;
    logic [31:0]               r_lo, w_lo_nxt;
    logic [32:0]               r_mag_a, w_mag_a_nxt;
    logic [63:0]               r_prod, w_prod_nxt;
    logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;
    logic                      r_neg, w_neg_nxt;
    logic [3:0]                r_op, w_op_nxt;
    logic                      r_done, w_done_nxt;

    logic                      w_abort;
    logic [32:0]               w_mag_a;
    logic [31:0]               w_mag_b;
    logic [BITS_PER_CYCLE-1:0] w_bits;
    logic [36:0]               w_addend;
    logic [36:0]               w_sum;
    logic [63:0]               w_step;
    logic [63:0]               w_p;
    logic [63:0]               w_hilo;
    logic [63:0]               w_result;

`ifdef HILO_ABORT_EN
    assign w_abort = Abort;
`else
    assign w_abort = 1'b0;
`endif

    // 33-bit magnitude so that -2^31 negates without overflow.
    assign w_mag_a = (Signed && A[31]) ? (33'd0 - {A[31], A}) : {1'b0, A};
    assign w_mag_b = (Signed && B[31]) ? (32'd0 - B) : B;

    // Right-shifting accumulator: multiplier sits in the low half of r_prod and is consumed
    // BITS_PER_CYCLE bits at a time while partial sums enter the high half.
    assign w_bits   = r_prod[BITS_PER_CYCLE-1:0];
    assign w_addend = 37'(r_mag_a) * 37'(w_bits);
    assign w_sum    = 37'(r_prod[63:32]) + w_addend;
    assign w_step   = 64'({w_sum, r_prod[31:0]} >> BITS_PER_CYCLE);

    assign w_p    = r_neg ? (64'd0 - r_prod) : r_prod;
    assign w_hilo = {r_hi, r_lo};

    always_comb begin
        w_result = w_p;
        case (r_op)
            OpMadd:  w_result = w_hilo + w_p;
            OpMsub:  w_result = w_hilo - w_p;
            default: w_result = w_p;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_mag_a_nxt = r_mag_a;
        w_prod_nxt  = r_prod;
        w_cnt_nxt   = r_cnt;
        w_neg_nxt   = r_neg;
        w_op_nxt    = r_op;
        w_done_nxt  = 1'b0;

        case (r_state)
            StIdle: begin
                if (Valid) begin
                    case (HiLoEnable)
                        OpMtlo: w_lo_nxt = A;
                        OpMthi: w_hi_nxt = A;
                        OpMult, OpMadd, OpMsub: begin
                            w_mag_a_nxt = w_mag_a;
                            w_prod_nxt  = {32'd0, w_mag_b};
                            w_neg_nxt   = Signed & (A[31] ^ B[31]);
                            w_op_nxt    = HiLoEnable;
                            w_cnt_nxt   = CNT_W'(ITER);
                            w_state_nxt = StMul;
                        end
                        default: ;
                    endcase
                end
            end
            StMul: begin
                w_prod_nxt = w_step;
                w_cnt_nxt  = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = StFin;
                end
            end
            StFin: begin
                w_hi_nxt    = w_result[63:32];
                w_lo_nxt    = w_result[31:0];
                w_done_nxt  = 1'b1;
                w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase

        // Abort wins over the FIN write; it is meaningless while idle.
        if (w_abort && (r_state != StIdle)) begin
            w_state_nxt = StIdle;
            w_hi_nxt    = r_hi;
            w_lo_nxt    = r_lo;
            w_done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= StIdle;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_mag_a <= 33'd0;
            r_prod  <= 64'd0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_op    <= 4'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_mag_a <= w_mag_a_nxt;
            r_prod  <= w_prod_nxt;
            r_cnt   <= w_cnt_nxt;
            r_neg   <= w_neg_nxt;
            r_op    <= w_op_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign Hi   = r_hi;
    assign Lo   = r_lo;
    assign Busy = (r_state != StIdle);
    assign Done = r_done;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Scoreboard bench for hilo_mult_unit: directed vectors, Done-triggered result monitor.
module tb_hilo_mult_unit;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Valid = 1'b0;
    logic [3:0]  HiLoEnable = 4'd0;
    logic        Signed = 1'b0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        Busy;
    logic        Done;
`ifdef HILO_ABORT_EN
    logic        Abort = 1'b0;
`endif

    int          checks = 0;
    int          errors = 0;
    int          n_done = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always #5 Clk = ~Clk;

    hilo_mult_unit dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Valid      (Valid),
        .HiLoEnable (HiLoEnable),
        .Signed     (Signed),
        .A          (A),
        .B          (B),
        .Hi         (Hi),
        .Lo         (Lo),
        .Busy       (Busy),
        .Done       (Done)
`ifdef HILO_ABORT_EN
        ,
        .Abort      (Abort)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every Done pulse must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        if (Done === 1'b1) begin
            n_done++;
            chk("done_has_expectation", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                chk("hilo_result", {Hi, Lo}, exp_q.pop_front());
            end
        end
    end

    // All tasks start and end at a negedge.
    task automatic issue(input logic [3:0] code, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b);
        Valid      = 1'b1;
        HiLoEnable = code;
        Signed     = sgn;
        A          = a;
        B          = b;
        @(posedge Clk);
        #1;
        Valid      = 1'b0;
        HiLoEnable = 4'd0;
        @(negedge Clk);
    endtask

    task automatic mt(input logic [3:0] code, input logic [31:0] a);
        issue(code, 1'b0, a, 32'd0);
        if (code == 4'd1) m_lo = a;
        else m_hi = a;
        chk("mt_hilo", {Hi, Lo}, {m_hi, m_lo});
        chk("mt_busy", 64'(Busy), 64'd0);
    endtask

    task automatic run_mul(input logic [3:0] code, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] expv, input bit poke);
        int cyc;
        exp_q.push_back(expv);
        Valid      = 1'b1;
        HiLoEnable = code;
        Signed     = sgn;
        A          = a;
        B          = b;
        @(posedge Clk);
        #1;
        Valid      = 1'b0;
        HiLoEnable = 4'd0;
        @(negedge Clk);
        chk("hold_during_busy", {Hi, Lo}, {m_hi, m_lo});
        cyc = 0;
        while (Busy === 1'b1 && cyc < 200) begin
            cyc++;
            if (poke && cyc == 5) begin
                Valid = 1'b1; HiLoEnable = 4'd1; A = 32'h1;
            end
            if (poke && cyc == 6) begin
                Valid = 1'b0; HiLoEnable = 4'd0;
            end
            if (cyc == 20) chk("hold_mid_busy", {Hi, Lo}, {m_hi, m_lo});
            @(negedge Clk);
        end
        chk("busy_cycles", 64'(cyc), 64'd33);
        chk("done_after_busy", 64'(Done), 64'd1);
        {m_hi, m_lo} = expv;
    endtask

    initial begin
        int d0;
        repeat (2) @(negedge Clk);
        chk("reset_hilo", {Hi, Lo}, 64'd0);
        chk("reset_busy_done", {62'd0, Busy, Done}, 64'd0);
        Rst_n = 1'b1;
        @(negedge Clk);

        mt(4'd1, 32'h12345678);
        mt(4'd2, 32'hCAFEF00D);

        // Back-to-back: each multiply is issued in the Done cycle of the previous one.
        run_mul(4'd3, 1'b1, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB, 1'b0);
        run_mul(4'd3, 1'b0, 32'hFFFFFFFD, 32'd7, 64'h00000006_FFFFFFEB, 1'b0);
        run_mul(4'd3, 1'b1, 32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000, 1'b0);

        mt(4'd2, 32'd0);
        mt(4'd1, 32'd10);
        run_mul(4'd4, 1'b1, 32'd2, 32'd3, 64'h00000000_00000010, 1'b0);
        mt(4'd1, 32'd5);
        run_mul(4'd5, 1'b1, 32'd2, 32'd3, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
        run_mul(4'd4, 1'b1, 32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFF9, 1'b0);

        // MTLO issued mid-operation must be ignored.
        run_mul(4'd3, 1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b1);
        @(negedge Clk);
        chk("mtlo_ignored", {Hi, Lo}, 64'h40000000_00000000);

        // Unused codes and Valid=0 leave state alone.
        issue(4'd7, 1'b0, 32'hDEADBEEF, 32'd1);
        chk("code7_noop", {Hi, Lo}, {m_hi, m_lo});
        HiLoEnable = 4'd1;
        A          = 32'h55555555;
        @(posedge Clk);
        #1;
        HiLoEnable = 4'd0;
        @(negedge Clk);
        chk("valid0_noop", {Hi, Lo}, {m_hi, m_lo});
        chk("noop_busy", 64'(Busy), 64'd0);

`ifdef HILO_ABORT_EN
        Valid = 1'b1; HiLoEnable = 4'd3; Signed = 1'b0; A = 32'd9; B = 32'd9;
        @(posedge Clk);
        #1;
        Valid = 1'b0; HiLoEnable = 4'd0;
        repeat (10) @(negedge Clk);
        Abort = 1'b1;
        @(posedge Clk);
        #1;
        Abort = 1'b0;
        chk("abort_busy", 64'(Busy), 64'd0);
        chk("abort_hilo", {Hi, Lo}, {m_hi, m_lo});
        d0 = n_done;
        repeat (40) @(negedge Clk);
        chk("abort_no_done", 64'(n_done), 64'(d0));
`endif

        // Asynchronous reset in the middle of a multiply.
        Valid = 1'b1; HiLoEnable = 4'd3; Signed = 1'b0; A = 32'd3; B = 32'd5;
        @(posedge Clk);
        #1;
        Valid = 1'b0; HiLoEnable = 4'd0;
        repeat (10) @(negedge Clk);
        chk("busy_before_reset", 64'(Busy), 64'd1);
        Rst_n = 1'b0;
        #1;
        chk("midop_reset_hilo", {Hi, Lo}, 64'd0);
        chk("midop_reset_busy", {62'd0, Busy, Done}, 64'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        d0 = n_done;
        repeat (40) @(negedge Clk);
        chk("reset_no_done", 64'(n_done), 64'(d0));
        chk("reset_hilo_stays", {Hi, Lo}, 64'd0);

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
